// File: rtl/fp16_sub_iter.sv
// Iterative FP16 subtractor (a - b) with valid/ready handshakes on both sides.
// Alignment and normalisation move one bit per cycle, so latency depends on the operands.
module fp16_sub_iter #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] result
);

  localparam int unsigned EW    = 5;
  localparam int unsigned MW    = 10;
  localparam int unsigned SW    = MW + 4;   // hidden, mantissa, G, R, S
  localparam int unsigned CW    = SW + 1;   // sum with carry
  localparam int unsigned CNTW  = 4;
  localparam int unsigned MAXSH = 14;

  localparam logic [EW-1:0]   EXP_MAX = '1;
  localparam logic [BITS-1:0] QNAN    = BITS'(16'h7E00);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t          state;
  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic            sign_x;
  logic            sign_y;
  logic [EW-1:0]   exp_x;
  logic [SW-1:0]   sig_x;
  logic [SW-1:0]   sig_y;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   sum;

  logic            a_nan, b_nan, a_inf, b_inf;
  logic [14:0]     mag_a, mag_b, x_mag, y_mag;
  logic            swap, x_sign, y_sign;
  logic [EW-1:0]   exp_diff;
  logic [CNTW-1:0] shift_cnt;
  logic [CW-1:0]   sum_c;
  logic            round_up;
  logic [MW:0]     man_rnd;
  logic [BITS-1:0] round_res;

  // Operand classification, ordering by magnitude, add/sub and rounding datapath.
  always_comb begin
    a_nan = (op_a[14:10] == EXP_MAX) && (op_a[9:0] != '0);
    b_nan = (op_b[14:10] == EXP_MAX) && (op_b[9:0] != '0);
    a_inf = (op_a[14:10] == EXP_MAX) && (op_a[9:0] == '0);
    b_inf = (op_b[14:10] == EXP_MAX) && (op_b[9:0] == '0);

    // Zero and denormal inputs collapse to a zero magnitude but keep their sign.
    mag_a = (op_a[14:10] == '0) ? '0 : op_a[14:0];
    mag_b = (op_b[14:10] == '0) ? '0 : op_b[14:0];

    swap   = mag_b > mag_a;
    x_mag  = swap ? mag_b : mag_a;
    y_mag  = swap ? mag_a : mag_b;
    x_sign = swap ? op_b[15] : op_a[15];
    y_sign = swap ? op_a[15] : op_b[15];

    exp_diff  = x_mag[14:10] - y_mag[14:10];
    shift_cnt = (exp_diff > EW'(MAXSH)) ? CNTW'(MAXSH) : exp_diff[CNTW-1:0];

    if (sign_x ^ sign_y)
      sum_c = {1'b0, sig_x} - {1'b0, sig_y};
    else
      sum_c = {1'b0, sig_x} + {1'b0, sig_y};

    round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
    man_rnd  = {1'b0, sum[12:3]} + (MW+1)'(round_up);
    // A mantissa carry bumps the exponent; exponent 31 with zero mantissa is infinity.
    if (man_rnd[MW])
      round_res = {sign_x, exp_x + 5'd1, 10'd0};
    else
      round_res = {sign_x, exp_x, man_rnd[MW-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sign_x    <= 1'b0;
      sign_y    <= 1'b0;
      exp_x     <= '0;
      sig_x     <= '0;
      sig_y     <= '0;
      cnt       <= '0;
      sum       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= {~b[15], b[14:0]};
            in_ready <= 1'b0;
            state    <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          if (a_nan || b_nan || (a_inf && b_inf && (op_a[15] != op_b[15]))) begin
            result    <= QNAN;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (a_inf) begin
            result    <= op_a;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (b_inf) begin
            result    <= op_b;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            sign_x <= x_sign;
            sign_y <= y_sign;
            exp_x  <= x_mag[14:10];
            sig_x  <= {|x_mag[14:10], x_mag[9:0], 3'b000};
            sig_y  <= {|y_mag[14:10], y_mag[9:0], 3'b000};
            cnt    <= shift_cnt;
            state  <= (exp_diff == '0) ? S_ADD : S_ALIGN;
          end
        end

        S_ALIGN: begin
          sig_y <= {1'b0, sig_y[SW-1:2], sig_y[1] | sig_y[0]};
          cnt   <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_ADD;
        end

        S_ADD: begin
          sum <= sum_c;
          if (sum_c == '0) begin
            result    <= '0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (sum_c[CW-1] || !sum_c[SW-1]) begin
            state <= S_NORM;
          end else begin
            state <= S_ROUND;
          end
        end

        S_NORM: begin
          if (sum[CW-1]) begin
            sum   <= {1'b0, sum[CW-1:2], sum[1] | sum[0]};
            exp_x <= exp_x + 5'd1;
            if (exp_x == EXP_MAX - 5'd1) begin
              result    <= {sign_x, EXP_MAX, 10'd0};
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_ROUND;
            end
          end else begin
            sum   <= {sum[CW-2:0], 1'b0};
            exp_x <= exp_x - 5'd1;
            if (exp_x == 5'd1) begin
              result    <= '0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else if (sum[SW-2]) begin
              state <= S_ROUND;
            end
          end
        end

        S_ROUND: begin
          result    <= round_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_sub_iter.sv
// Bench for fp16_sub_iter: directed cases, handshake/reset scenarios and random
// operands checked against an exact-arithmetic FP16 reference.
module tb_fp16_sub_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp16_sub_iter #(.BITS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  // Value in units of 2^-24; denormals and zeros count as zero.
  function automatic longint to_units(input logic [15:0] v);
    longint m;
    if (v[14:10] == 5'd0) return 0;
    m = longint'({1'b1, v[9:0]}) << (int'(v[14:10]) - 1);
    return v[15] ? -m : m;
  endfunction

  // a - b from exact arithmetic, rounded to nearest-even, with tiny results flushed to +0.
  function automatic logic [15:0] ref_sub(input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] nb;
    bit a_nan, b_nan, a_inf, b_inf, neg;
    longint v, mag, q, rem, half;
    int p, sh, e;
    nb    = bv ^ 16'h8000;
    a_nan = (av[14:10] == 5'h1F) && (av[9:0] != 0);
    b_nan = (bv[14:10] == 5'h1F) && (bv[9:0] != 0);
    a_inf = (av[14:10] == 5'h1F) && (av[9:0] == 0);
    b_inf = (bv[14:10] == 5'h1F) && (bv[9:0] == 0);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf && (av[15] != nb[15])) return 16'h7E00;
    if (a_inf) return av;
    if (b_inf) return nb;
    v   = to_units(av) + to_units(nb);
    neg = v < 0;
    mag = neg ? -v : v;
    if (mag < 1024) return 16'h0000;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    sh = p - 10;
    q  = mag >> sh;
    if (sh > 0) begin
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 2048) begin
        q  = 1024;
        sh = sh + 1;
      end
    end
    e = sh + 1;
    if (e >= 31) return {neg, 5'h1F, 10'h000};
    return {neg, 5'(e), q[9:0]};
  endfunction

  // Present one operand pair and return one time unit after the accept edge.
  task automatic accept_op(input logic [15:0] av, input logic [15:0] bv);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_wait in_ready=%b required=1", in_ready);
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
  endtask

  // Cycles from the accept edge to the first out_valid; -1 when the budget runs out.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0000", result);
    end
  endtask

  task automatic test_directed();
    logic [15:0] da [14] = '{16'h4200, 16'h3C00, 16'h3C01, 16'h3C00, 16'h3C01, 16'h7BFF, 16'h7C00,
                             16'h7E00, 16'h3C00, 16'h7C00, 16'h3C00, 16'h0001, 16'h0400, 16'h3C00};
    logic [15:0] db [14] = '{16'h3C00, 16'hBC00, 16'h3C00, 16'h9000, 16'h9000, 16'hFBFF, 16'h7C00,
                             16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00, 16'h3C00, 16'h0001, 16'hFC00};
    logic [15:0] dr [14] = '{16'h4000, 16'h4000, 16'h1400, 16'h3C00, 16'h3C02, 16'h7C00, 16'h7E00,
                             16'h7E00, 16'h0000, 16'h7C00, 16'hFC00, 16'hBC00, 16'h0400, 16'h7C00};
    int          dl [14] = '{5, 5, 14, 15, 15, -1, 2, 2, 3, 2, 2, 18, 5, 2};
    int lat;
    for (int i = 0; i < 14; i++) begin
      accept_op(da[i], db[i]);
      wait_out(lat);
      checks++;
      if (lat < 0 || result !== dr[i]) begin
        failures++;
        $display("FAIL directed[%0d] %h-%h result=%h exp=%h lat=%0d", i, da[i], db[i], result, dr[i], lat);
      end
      if (dl[i] >= 0) begin
        checks++;
        if (lat != dl[i]) begin
          failures++;
          $display("FAIL latency[%0d] %h-%h got=%0d exp=%0d", i, da[i], db[i], lat, dl[i]);
        end
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept_op(16'h4200, 16'h3C00);
    wait_out(lat);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h4000) begin
        failures++;
        $display("FAIL hold[%0d] out_valid=%b result=%h exp 1/4000", c, out_valid, result);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_in_ready[%0d] got=%b exp=0", c, in_ready);
      end
      @(negedge clk);
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_handshake in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    accept_op(16'h3C00, 16'hBC00);
    wait_out(lat);
    checks++;
    if (lat != 5 || result !== 16'h4000) begin
      failures++;
      $display("FAIL back_to_back result=%h lat=%0d exp 4000/5", result, lat);
    end
    release_out();
  endtask

  task automatic test_reset_mid_op();
    bit seen = 1'b0;
    int lat;
    accept_op(16'h3C00, 16'h0400);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b result=%h exp 0/1/0000", out_valid, in_ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL discarded_op out_valid seen=1 exp=0");
    end
    accept_op(16'h4200, 16'h3C00);
    wait_out(lat);
    checks++;
    if (lat != 5 || result !== 16'h4000) begin
      failures++;
      $display("FAIL post_reset_op result=%h lat=%0d exp 4000/5", result, lat);
    end
    release_out();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] av, bv, expv;
      int lat, mode, hold;
      av   = 16'($urandom);
      bv   = 16'($urandom);
      mode = int'($urandom_range(0, 3));
      case (mode)
        1: bv[14:10] = av[14:10] ^ 5'($urandom_range(0, 3));
        2: bv = {av[15], av[14:0] ^ 15'($urandom_range(0, 31))};
        3: begin
          av[14:12] = 3'b000;
          bv[14:12] = 3'b000;
        end
        default: ;
      endcase
      expv = ref_sub(av, bv);
      hold = int'($urandom_range(0, 3));
      accept_op(av, bv);
      wait_out(lat);
      repeat (hold) @(negedge clk);
      checks++;
      if (lat < 0 || result !== expv) begin
        failures++;
        $display("FAIL random[%0d] %h-%h result=%h exp=%h lat=%0d", i, av, bv, result, expv, lat);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
